bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_pkg.sv | 14 +
 rtl/bus_arbiter_timer.sv | 37 +++
 rtl/bus_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the bus arbiter: data bus width, the all-bytes
// byte-enable constant and the arbiter FSM state encodings.
package bus_arbiter_pkg;

  localparam int          BUS_W   = 32;
  localparam logic [3:0]  SEL_ALL = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IF_ACC = 2'd1,
    ST_DM_ACC = 2'd2
  } state_e;

endpackage

// File: rtl/bus_arbiter_timer.sv
// arb_timer: bus-cycle timeout counter for the bus arbiter.
// Only present when ARB_TIMEOUT_EN is defined; without it the arbiter waits
// indefinitely and this module is not built.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   clear_i     reload the counter (asserted while the arbiter is idle)
//   enable_i    count one cycle spent in a bus access
//   expired_o   current access cycle is the TIMEOUT_CYCLES-th without ack
`ifdef ARB_TIMEOUT_EN
module arb_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  // Down-counter: loaded with TIMEOUT_CYCLES-1 so that terminal count (zero)
  // coincides with the last allowed access cycle.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      cnt_q <= CW'(TIMEOUT_CYCLES - 1);
    end else if (enable_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired_o = enable_i && (cnt_q == '0);

endmodule
`endif

// File: rtl/bus_arbiter.sv
// bus_arbiter: fixed-priority arbiter sharing one bus between an instruction
// fetch port and a data port. Data wins ties. All bus outputs are registered.
// Optional feature: define ARB_TIMEOUT_EN to terminate bus cycles that get no
// acknowledge within TIMEOUT_CYCLES, returning rdata 0 with an err_o pulse.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   if_req_i/if_addr_i          fetch request and address
//   if_rdata_o/if_ack_o         fetched word, one-cycle completion pulse
//   dm_req_i/we/sel/addr/wdata  data request and attributes
//   dm_rdata_o/dm_ack_o         read data, one-cycle completion pulse
//   bus_*_o / bus_rdata_i/ack_i shared bus master interface
//   stall_req_o                 combinational pipeline stall request
//   err_o                       timeout error pulse (0 without ARB_TIMEOUT_EN)
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req_i,
  input  logic [BUS_W-1:0] if_addr_i,
  output logic [BUS_W-1:0] if_rdata_o,
  output logic             if_ack_o,
  input  logic             dm_req_i,
  input  logic             dm_we_i,
  input  logic [3:0]       dm_sel_i,
  input  logic [BUS_W-1:0] dm_addr_i,
  input  logic [BUS_W-1:0] dm_wdata_i,
  output logic [BUS_W-1:0] dm_rdata_o,
  output logic             dm_ack_o,
  output logic             bus_cyc_o,
  output logic             bus_stb_o,
  output logic             bus_we_o,
  output logic [3:0]       bus_sel_o,
  output logic [BUS_W-1:0] bus_addr_o,
  output logic [BUS_W-1:0] bus_wdata_o,
  input  logic [BUS_W-1:0] bus_rdata_i,
  input  logic             bus_ack_i,
  output logic             stall_req_o,
  output logic             err_o
);

  state_e           state_q;
  logic [BUS_W-1:0] if_rdata_q, dm_rdata_q, addr_q, wdata_q;
  logic             if_ack_q, dm_ack_q, cyc_q, we_q;
  logic [3:0]       sel_q;
  logic             timeout;
  logic             in_acc;
  logic [BUS_W-1:0] done_rdata;

  assign in_acc     = (state_q != ST_IDLE);
  // A timed-out cycle returns zero; a real ack always wins over timeout.
  assign done_rdata = bus_ack_i ? bus_rdata_i : '0;

`ifdef ARB_TIMEOUT_EN
  logic err_q;

  arb_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (!in_acc),
    .enable_i (in_acc),
    .expired_o(timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= in_acc && timeout && !bus_ack_i;
    end
  end

  assign err_o = err_q;
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // A requester whose ack is showing this cycle is still holding its
          // request from the completed transfer; do not grant it again.
          if (dm_req_i && !dm_ack_q) begin
            state_q <= ST_DM_ACC;
            cyc_q   <= 1'b1;
            we_q    <= dm_we_i;
            sel_q   <= dm_sel_i;
            addr_q  <= dm_addr_i;
            wdata_q <= dm_wdata_i;
          end else if (if_req_i && !if_ack_q) begin
            state_q <= ST_IF_ACC;
            cyc_q   <= 1'b1;
            we_q    <= 1'b0;
            sel_q   <= SEL_ALL;
            addr_q  <= if_addr_i;
            wdata_q <= '0;
          end else begin
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
          end
        end
        ST_IF_ACC, ST_DM_ACC: begin
          if (bus_ack_i || timeout) begin
            state_q <= ST_IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            if (state_q == ST_IF_ACC) begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= done_rdata;
            end else begin
              dm_ack_q   <= 1'b1;
              dm_rdata_q <= done_rdata;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign if_rdata_o  = if_rdata_q;
  assign if_ack_o    = if_ack_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign dm_ack_o    = dm_ack_q;
  assign bus_cyc_o   = cyc_q;
  assign bus_stb_o   = cyc_q;
  assign bus_we_o    = we_q;
  assign bus_sel_o   = sel_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign stall_req_o = (if_req_i & ~if_ack_q) | (dm_req_i & ~dm_ack_q);

endmodule
